// File: rtl/rom_reg_loader_pkg.sv
// ---------------------------------------------------------------------------
// rom_reg_loader_pkg
// Shared constants for the ROM-to-register-bank loader and its bank.
//   ST_*        : loader FSM state encodings
//   BANK_DEPTH  : number of bank entries (one per mux input)
//   SEL_W       : width of the mux select / bank write index
// ---------------------------------------------------------------------------
package rom_reg_loader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  localparam int BANK_DEPTH = 4;
  localparam int SEL_W      = 2;

endpackage

// File: rtl/rom_reg_loader_bank.sv
// ---------------------------------------------------------------------------
// reg_bank4
// Four-entry register bank feeding the 4-to-1 mux data inputs.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high clear of all entries
//   we     : write enable
//   widx   : entry index written when we=1
//   wdata  : write data
//   q0..q3 : current entry contents (mux in0..in3)
// ---------------------------------------------------------------------------
module reg_bank4
  import rom_reg_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [SEL_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q0,
  output logic [DATA_WIDTH-1:0] q1,
  output logic [DATA_WIDTH-1:0] q2,
  output logic [DATA_WIDTH-1:0] q3
);

  logic [DATA_WIDTH-1:0] bank [BANK_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) bank[i] <= '0;
    end else if (we) begin
      bank[widx] <= wdata;
    end
  end

  assign q0 = bank[0];
  assign q1 = bank[1];
  assign q2 = bank[2];
  assign q3 = bank[3];

endmodule

// File: rtl/rom_reg_loader.sv
// ---------------------------------------------------------------------------
// rom_reg_loader
// On start, reads four consecutive ROM words into a 4-entry bank, then steps
// the mux select 0..3 (each value held HOLD_CYCLES cycles) and pulses done.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, base_addr  : launch request and first ROM address (idle only)
//   rom_en, rom_addr  : synchronous ROM read request
//   rom_data          : ROM read data, valid one cycle after the request edge
//   reg0..reg3        : bank entries, to mux in0..in3
//   sel, sel_valid    : mux select and its qualifier
//   busy, done        : sequence in progress, one-cycle completion pulse
// ---------------------------------------------------------------------------
module rom_reg_loader
  import rom_reg_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] reg0,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic [DATA_WIDTH-1:0] reg3,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        state;
  // Edges elapsed in LOAD: 0..2 issue the next address, 3 ends the issue
  // phase, 1..4 capture the word requested two edges earlier.
  logic [2:0]        load_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              bank_we;
  logic [SEL_W-1:0]  bank_widx;

  // Capture stage: ROM word for entry k lands on LOAD edge k+1.
  assign bank_we   = (state == ST_LOAD) && (load_cnt != 3'd0);
  assign bank_widx = load_cnt[1:0] - 2'd1;

  reg_bank4 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .widx  (bank_widx),
    .wdata (rom_data),
    .q0    (reg0),
    .q1    (reg1),
    .q2    (reg2),
    .q3    (reg3)
  );

  // Control: FSM, address counter and select hold counter.
  // rom_addr doubles as the latched base address; it is loaded with
  // base_addr on the start edge and only ever incremented after that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      load_cnt  <= '0;
      hold_cnt  <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            rom_en   <= 1'b1;
            rom_addr <= base_addr;
            load_cnt <= '0;
          end
        end
        ST_LOAD: begin
          load_cnt <= load_cnt + 3'd1;
          if (load_cnt < 3'd3) rom_addr <= rom_addr + ADDR_WIDTH'(1);
          if (load_cnt == 3'd3) rom_en <= 1'b0;
          if (load_cnt == 3'd4) begin
            state     <= ST_SCAN;
            sel       <= '0;
            sel_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        ST_SCAN: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (sel == SEL_W'(BANK_DEPTH - 1)) begin
              state     <= ST_IDLE;
              sel       <= '0;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reg_loader.sv
module tb_rom_reg_loader;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int HOLD = 2;
  localparam int LAT  = 5 + 4 * HOLD;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] reg0, reg1, reg2, reg3;
  logic [1:0]    sel;
  logic          sel_valid, busy, done;

  logic [DW-1:0] rom [0:255];

  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  logic [1:0]    q_sel  [$];

  int vectors     = 0;
  int miscompares = 0;

  logic [141:0] all_out;
  assign all_out = {rom_en, rom_addr, reg0, reg1, reg2, reg3, sel, sel_valid, busy, done};

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the sampling edge.
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  rom_reg_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .reg0      (reg0),
    .reg1      (reg1),
    .reg2      (reg2),
    .reg3      (reg3),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: outputs %h, want all zero", all_out);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    // Reset during LOAD, after reg0 has been written.
    for (int k = 0; k < 4; k++) rom[8'h10 + k] = 32'hC0DE_0000 + k;
    start = 1'b1; base_addr = 8'h10;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (reg0 !== 32'hC0DE_0000) begin
      miscompares++;
      $display("FAIL reset_preload_reg0: got %h want %h", reg0, 32'hC0DE_0000);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_async_load: outputs %h, want all zero", all_out);
    end
    @(negedge clk); reset = 1'b0;
    begin
      int bad = 0;
      for (int n = 0; n < LAT + 4; n++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL reset_after_release: %0d cycles with busy/done high, want 0", bad);
      end
    end
  endtask

  task automatic test_load(input logic [AW-1:0] base, input logic [DW-1:0] d0, d1, d2, d3,
                           input bit poke_busy);
    logic [DW-1:0] d [4];
    logic [DW-1:0] regs [4];
    logic [AW-1:0] a, ea;
    logic [DW-1:0] ed;
    logic [1:0]    es;
    int            done_cnt;
    d = '{d0, d1, d2, d3};
    q_addr.delete(); q_data.delete(); q_sel.delete();
    for (int k = 0; k < 4; k++) begin
      a = base + AW'(k);
      rom[a] = d[k];
      q_addr.push_back(a);
      q_data.push_back(d[k]);
    end
    for (int s = 0; s < 4; s++) repeat (HOLD) q_sel.push_back(2'(s));
    done_cnt = 0;
    @(negedge clk); start = 1'b1; base_addr = base;
    @(negedge clk); start = 1'b0; base_addr = ~base;
    for (int n = 0; n <= LAT + 3; n++) begin
      vectors++;
      if (busy !== 1'(n < LAT)) begin
        miscompares++;
        $display("FAIL load_busy n=%0d: got %b want %b", n, busy, 1'(n < LAT));
      end
      if (rom_en) begin
        vectors++;
        if (q_addr.size() == 0) begin
          miscompares++;
          $display("FAIL load_rom_en n=%0d: got rom_en=1 addr %h want no read", n, rom_addr);
        end else begin
          ea = q_addr.pop_front();
          if (rom_addr !== ea) begin
            miscompares++;
            $display("FAIL load_rom_addr n=%0d: got %h want %h", n, rom_addr, ea);
          end
        end
      end
      if (sel_valid) begin
        vectors++;
        if (q_sel.size() == 0) begin
          miscompares++;
          $display("FAIL load_sel_valid n=%0d: got sel_valid=1 want 0", n);
        end else begin
          es = q_sel.pop_front();
          if (sel !== es) begin
            miscompares++;
            $display("FAIL load_sel n=%0d: got %0d want %0d", n, sel, es);
          end
        end
      end
      if (done) begin
        done_cnt++;
        vectors++;
        if (n != LAT || sel !== 2'd0) begin
          miscompares++;
          $display("FAIL load_done_time: got n=%0d sel=%0d want n=%0d sel=0", n, sel, LAT);
        end
        regs = '{reg0, reg1, reg2, reg3};
        for (int k = 0; k < 4; k++) begin
          vectors++;
          ed = (q_data.size() != 0) ? q_data.pop_front() : 'x;
          if (regs[k] !== ed) begin
            miscompares++;
            $display("FAIL load_reg%0d: got %h want %h", k, regs[k], ed);
          end
        end
      end
      if (poke_busy) begin
        start = (n == 2);
        if (n == 2) base_addr = 8'h40;
      end
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (q_addr.size() != 0 || q_sel.size() != 0 || q_data.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL load_complete: left addr=%0d sel=%0d data=%0d done_cnt=%0d, want 0 0 0 1",
               q_addr.size(), q_sel.size(), q_data.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int k = 0; k < 4; k++) rom[8'h20 + k] = 32'h5CA0_0000 + k;
    @(negedge clk); start = 1'b1; base_addr = 8'h20;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (sel !== 2'd2 || sel_valid !== 1'b1 || reg3 !== 32'h5CA0_0003) begin
      miscompares++;
      $display("FAIL scan_pre_reset: sel=%0d vld=%b reg3=%h want 2 1 %h", sel, sel_valid, reg3,
               32'h5CA0_0003);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL scan_reset_async: outputs %h, want all zero", all_out);
    end
    @(negedge clk); reset = 1'b0;
    begin
      int bad = 0;
      for (int n = 0; n < LAT + 4; n++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || sel_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL scan_reset_no_done: %0d bad cycles, want 0", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] bases [2];
    logic [DW-1:0] regs [4];
    logic [AW-1:0] a, ea;
    logic [DW-1:0] ed;
    logic [1:0]    es;
    logic          exp_busy, exp_done;
    int            done_cnt;
    bases = '{8'h30, 8'h80};
    q_addr.delete(); q_data.delete(); q_sel.delete();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        a = bases[s] + AW'(k);
        rom[a] = 32'hB2B0_0000 + 32'(s * 16 + k);
        q_addr.push_back(a);
        q_data.push_back(rom[a]);
      end
      for (int v = 0; v < 4; v++) repeat (HOLD) q_sel.push_back(2'(v));
    end
    done_cnt = 0;
    @(negedge clk); start = 1'b1; base_addr = bases[0];
    @(negedge clk);
    for (int n = 0; n <= 2 * LAT + 3; n++) begin
      exp_busy = !(n == LAT || n > 2 * LAT);
      exp_done = (n == LAT || n == 2 * LAT + 1);
      vectors++;
      if (busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL b2b_busy_done n=%0d: got %b%b want %b%b", n, busy, done, exp_busy, exp_done);
      end
      if (rom_en) begin
        vectors++;
        ea = (q_addr.size() != 0) ? q_addr.pop_front() : 'x;
        if (rom_addr !== ea) begin
          miscompares++;
          $display("FAIL b2b_rom_addr n=%0d: got %h want %h", n, rom_addr, ea);
        end
      end
      if (sel_valid) begin
        vectors++;
        es = (q_sel.size() != 0) ? q_sel.pop_front() : 'x;
        if (sel !== es) begin
          miscompares++;
          $display("FAIL b2b_sel n=%0d: got %0d want %0d", n, sel, es);
        end
      end
      if (done) begin
        done_cnt++;
        regs = '{reg0, reg1, reg2, reg3};
        for (int k = 0; k < 4; k++) begin
          vectors++;
          ed = (q_data.size() != 0) ? q_data.pop_front() : 'x;
          if (regs[k] !== ed) begin
            miscompares++;
            $display("FAIL b2b_reg%0d n=%0d: got %h want %h", k, n, regs[k], ed);
          end
        end
      end
      if (n == 5) base_addr = bases[1];
      if (n == LAT + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (q_addr.size() != 0 || q_sel.size() != 0 || q_data.size() != 0 || done_cnt != 2) begin
      miscompares++;
      $display("FAIL b2b_complete: left addr=%0d sel=%0d data=%0d done_cnt=%0d, want 0 0 0 2",
               q_addr.size(), q_sel.size(), q_data.size(), done_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    for (int i = 0; i < 256; i++) rom[i] = 32'hDEAD_0000 + 32'(i);
    test_reset();
    test_load(8'h00, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b0);
    test_load(8'hFE, 32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000D, 1'b0);
    test_load(8'h50, 32'h5050_0001, 32'h5050_0002, 32'h5050_0003, 32'h5050_0004, 1'b1);
    test_reset_mid_scan();
    test_load(8'h60, 32'h6060_AAAA, 32'h6060_BBBB, 32'h6060_CCCC, 32'h6060_DDDD, 1'b0);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_reg_loader.md
Name: rom_reg_loader

Overview:
- Upstream feeder for the 32-bit 4-to-1 mux in the Rom-Register project.
- On `start`, reads four consecutive words from a synchronous ROM into a 4-entry register bank. The bank outputs drive the mux data inputs `in0`..`in3`.
- Then steps the mux select through 0..3, holding each value for a fixed number of cycles, and reports completion.

Parameters:
- DATA_WIDTH, 32, width of ROM words and bank registers.
- ADDR_WIDTH, 8, ROM address width.
- HOLD_CYCLES, 2, cycles each select value is held during scan (must be at least 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load+scan sequence; sampled only when idle.
- base_addr  input  ADDR_WIDTH  first ROM address; latched with start.
- rom_en  output  1  ROM read enable.
- rom_addr  output  ADDR_WIDTH  ROM read address.
- rom_data  input  DATA_WIDTH  ROM read data, valid one cycle after the edge that samples rom_en/rom_addr.
- reg0  output  DATA_WIDTH  bank entry 0, to mux in0.
- reg1  output  DATA_WIDTH  bank entry 1, to mux in1.
- reg2  output  DATA_WIDTH  bank entry 2, to mux in2.
- reg3  output  DATA_WIDTH  bank entry 3, to mux in3.
- sel  output  2  mux select.
- sel_valid  output  1  sel is meaningful (scan in progress).
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs registered and cleared to 0, including reg0..reg3, sel, rom_addr, rom_en, sel_valid, busy and done. FSM goes to IDLE.
- FSM states are IDLE, LOAD and SCAN.
- IDLE:
  - If start is 1 at edge E0: latch base_addr, go to LOAD.
  - After E0: busy=1, rom_en=1, rom_addr=base_addr.
- LOAD (pipelined issue and capture):
  - After E1, E2, E3: rom_addr = base+1, base+2, base+3.
  - After E4: rom_en=0.
  - Entry k is written from rom_data at edge E(k+2): reg0 at E2 through reg3 at E5.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - Bank entries not yet written keep their previous contents.
- SCAN:
  - After E5: sel=0, sel_valid=1.
  - sel increments every HOLD_CYCLES edges: with default 2, sel=1 after E7, 2 after E9, 3 after E11.
  - After E(5+4*HOLD_CYCLES) (E13 with default): sel_valid=0, sel returns to 0, busy=0, done=1 for exactly one cycle, state IDLE.
- Bank contents persist after the sequence until overwritten by a later load or reset.
- start while busy=1 is ignored, with no queuing.
- start during the done cycle is accepted; that cycle counts as IDLE.
- base_addr changes after E0 have no effect on the sequence in flight.
- Reset asserted mid-sequence:
  - All outputs, including bank contents, clear immediately (asynchronously).
  - FSM returns to IDLE; no done pulse is issued.
- Total latency from start edge to done: 5 + 4*HOLD_CYCLES cycles.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, LOAD=2'd1, SCAN=2'd2).
  - Bank depth constant (4).
  - Select width constant (2).
- One natural sub-module, reg_bank4: 4 x DATA_WIDTH register bank with asynchronous reset, write enable and 2-bit write index. It exposes all four entries as outputs.
- FSM, address counter and hold counter stay in rom_reg_loader.

Test Plan:
- Reset check: assert reset mid-run → every output reads 0 immediately after reset asserts; after release, idle with busy=0.
- Basic load: ROM[0..3]=0x11111111,0x22222222,0x33333333,0x44444444, base_addr=0, start pulse at E0 →
  - rom_addr 0,1,2,3 after E0..E3; rom_en low after E4.
  - reg0..reg3 hold those four values after E5.
  - sel 0,1,2,3 each for 2 cycles from E5.
  - done pulses after E13.
- Wrap-around: base_addr=0xFE, ROM[0xFE]=0xA, [0xFF]=0xB, [0x00]=0xC, [0x01]=0xD → rom_addr sequence 0xFE,0xFF,0x00,0x01; reg0..reg3 = 0xA,0xB,0xC,0xD.
- Start while busy: second start pulse at E3 with base_addr=0x40 → ignored; addresses continue base+3; exactly one done pulse.
- Reset mid-SCAN: reset asserted while sel=2 →
  - sel, sel_valid, busy and reg0..reg3 all 0 immediately, no done pulse.
  - A new start after release runs a full sequence normally.
- Back-to-back: start held high through the done cycle → a second sequence begins; rom_addr=base_addr after that edge; busy deasserts for exactly one cycle.
